// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared geometry constants, bus widths and FSM state encoding
//                for the convolution scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int IMG_SIZE    = 7;
    localparam int KERNEL_SIZE = 3;
    localparam int RES_SIZE    = IMG_SIZE - KERNEL_SIZE + 1;

    localparam int IMG_AW  = 6;
    localparam int KER_AW  = 4;
    localparam int FM_AW   = 5;
    localparam int FM_DW   = 11;
    localparam int DATA_W  = 4;
    localparam int PROD_W  = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_ROM = 3'd2,
        MUL      = 3'd3,
        ACC      = 3'd4,
        EMIT     = 3'd5,
        FIN      = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : conv_addr_gen
//  Description : Combinational mapping from window position (wr, wc) and
//                kernel tap (kr, kc) to row-major image and kernel addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_addr_gen #(
    parameter int IMG_SIZE    = conv_pkg::IMG_SIZE,
    parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE
) (
    input  logic [2:0] wr,
    input  logic [2:0] wc,
    input  logic [1:0] kr,
    input  logic [1:0] kc,
    output logic [5:0] img_addr,
    output logic [3:0] ker_addr
);
    import conv_pkg::*;

    // Pixel under the current tap: row (wr+kr), column (wc+kc)
    assign img_addr = IMG_AW'(IMG_SIZE * (int'(wr) + int'(kr)) + int'(wc) + int'(kc));
    assign ker_addr = KER_AW'(KERNEL_SIZE * int'(kr) + int'(kc));

endmodule
`default_nettype wire

// File: rtl/conv_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : conv_scheduler
//  Description : Sequences a full 2-D valid convolution of an image ROM with a
//                kernel ROM through an external handshaked multiplier, and
//                streams each window sum out on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_scheduler #(
    parameter int IMG_SIZE    = conv_pkg::IMG_SIZE,
    parameter int KERNEL_SIZE = conv_pkg::KERNEL_SIZE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [5:0]  img_addr,
    input  logic [3:0]  img_data,
    output logic [3:0]  ker_addr,
    input  logic [3:0]  ker_data,
    output logic        mul_req,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic        mul_ack,
    input  logic [7:0]  mul_prod,
    output logic        fm_valid,
    input  logic        fm_ready,
    output logic [4:0]  fm_addr,
    output logic [10:0] fm_data
);
    import conv_pkg::*;

    localparam int         c_res_size = IMG_SIZE - KERNEL_SIZE + 1;
    localparam logic [1:0] c_k_last   = 2'(KERNEL_SIZE - 1);
    localparam logic [2:0] c_w_last   = 3'(c_res_size - 1);
    localparam logic [4:0] c_pix_last = 5'(c_res_size * c_res_size - 1);

    state_t      r_state;
    logic [2:0]  r_wr;
    logic [2:0]  r_wc;
    logic [1:0]  r_kr;
    logic [1:0]  r_kc;
    logic [4:0]  r_pix;
    logic [10:0] r_acc;
    logic [7:0]  r_prod;
    logic [10:0] w_sum;

    // Addresses follow the counters directly; the counters only move in
    // ACC/EMIT, so the address is stable across the FETCH cycle.
    conv_addr_gen #(
        .IMG_SIZE    (IMG_SIZE),
        .KERNEL_SIZE (KERNEL_SIZE)
    ) u_addr_gen (
        .wr       (r_wr),
        .wc       (r_wc),
        .kr       (r_kr),
        .kc       (r_kc),
        .img_addr (img_addr),
        .ker_addr (ker_addr)
    );

    // Accumulator plus the product captured at mul_ack
    assign w_sum = r_acc + {3'b000, r_prod};

    // Scheduler FSM with registered handshake, status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_wr     <= '0;
            r_wc     <= '0;
            r_kr     <= '0;
            r_kc     <= '0;
            r_pix    <= '0;
            r_acc    <= '0;
            r_prod   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mul_req  <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            fm_valid <= 1'b0;
            fm_addr  <= '0;
            fm_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_wr    <= '0;
                        r_wc    <= '0;
                        r_kr    <= '0;
                        r_kc    <= '0;
                        r_pix   <= '0;
                        r_acc   <= '0;
                        busy    <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_state <= WAIT_ROM;
                end
                WAIT_ROM: begin
                    // ROM data for the FETCH address is valid now
                    mul_a   <= img_data;
                    mul_b   <= ker_data;
                    mul_req <= 1'b1;
                    r_state <= MUL;
                end
                MUL: begin
                    // Product is only valid in the ack cycle, so capture it here
                    if (mul_ack) begin
                        r_prod  <= mul_prod;
                        mul_req <= 1'b0;
                        r_state <= ACC;
                    end
                end
                ACC: begin
                    r_acc <= w_sum;
                    if (r_kr == c_k_last && r_kc == c_k_last) begin
                        fm_data  <= w_sum;
                        fm_addr  <= r_pix;
                        fm_valid <= 1'b1;
                        r_state  <= EMIT;
                    end else begin
                        if (r_kc == c_k_last) begin
                            r_kc <= '0;
                            r_kr <= r_kr + 2'd1;
                        end else begin
                            r_kc <= r_kc + 2'd1;
                        end
                        r_state <= FETCH;
                    end
                end
                EMIT: begin
                    if (fm_ready) begin
                        fm_valid <= 1'b0;
                        r_acc    <= '0;
                        r_kr     <= '0;
                        r_kc     <= '0;
                        r_pix    <= r_pix + 5'd1;
                        if (r_wc == c_w_last) begin
                            r_wc <= '0;
                            r_wr <= (r_wr == c_w_last) ? 3'd0 : r_wr + 3'd1;
                        end else begin
                            r_wc <= r_wc + 3'd1;
                        end
                        if (r_pix == c_pix_last) begin
                            done    <= 1'b1;
                            r_state <= FIN;
                        end else begin
                            r_state <= FETCH;
                        end
                    end
                end
                FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_scheduler
//  Description : Self-checking bench for conv_scheduler with ROM and
//                handshaked-multiplier models and a pixel scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [5:0]  img_addr;
    logic [3:0]  img_data = '0;
    logic [3:0]  ker_addr;
    logic [3:0]  ker_data = '0;
    logic        mul_req;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic        mul_ack;
    logic [7:0]  mul_prod;
    logic        fm_valid;
    logic        fm_ready = 1'b0;
    logic [4:0]  fm_addr;
    logic [10:0] fm_data;

    int checks = 0;
    int errors = 0;

    conv_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .img_addr (img_addr),
        .img_data (img_data),
        .ker_addr (ker_addr),
        .ker_data (ker_data),
        .mul_req  (mul_req),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_ack  (mul_ack),
        .mul_prod (mul_prod),
        .fm_valid (fm_valid),
        .fm_ready (fm_ready),
        .fm_addr  (fm_addr),
        .fm_data  (fm_data)
    );

    always #5 clk = ~clk;

    // ROM models: one-cycle read latency
    logic [3:0] img_rom [64];
    logic [3:0] ker_rom [16];
    always @(posedge clk) begin
        img_data <= img_rom[img_addr];
        ker_data <= ker_rom[ker_addr];
    end

    // Multiplier model with programmable ack delay and optional stray acks
    int   ack_delay = 0;
    int   ack_cnt = 0;
    logic stray_ack = 1'b0;
    assign mul_ack  = (mul_req && (ack_cnt >= ack_delay)) || stray_ack;
    assign mul_prod = {4'b0000, mul_a} * {4'b0000, mul_b};
    always @(posedge clk) begin
        if (mul_req && !mul_ack) ack_cnt <= ack_cnt + 1;
        else                     ack_cnt <= 0;
    end

    typedef struct {
        logic [4:0]  addr;
        logic [10:0] data;
    } exp_t;
    exp_t sb[$];

    task automatic push_expected();
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                int   s;
                exp_t e;
                s = 0;
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++)
                        s += int'(img_rom[7*(r+kr) + c + kc]) * int'(ker_rom[3*kr + kc]);
                e.addr = 5'(5*r + c);
                e.data = 11'(s);
                sb.push_back(e);
            end
        end
    endtask

    task automatic load_roms(input int mode);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0:       img_rom[i] = 4'd1;
                1:       img_rom[i] = 4'(i % 16);
                2:       img_rom[i] = 4'd15;
                default: img_rom[i] = 4'($urandom_range(0, 15));
            endcase
        end
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0:       ker_rom[i] = 4'd1;
                1:       ker_rom[i] = (i == 4) ? 4'd1 : 4'd0;
                2:       ker_rom[i] = 4'd15;
                default: ker_rom[i] = 4'($urandom_range(0, 15));
            endcase
        end
    endtask

    // Runs one pass from a start pulse, checking every accepted pixel
    // against the scoreboard and handshake stability along the way.
    task automatic collect_pass(input int stall_addr, input int restart_at, input bit check_latency);
        int          cyc = 0;
        int          first_valid = -1;
        int          npix = 0;
        int          ndone = 0;
        int          stall_left = 5;
        int          after = -1;
        bit          fpend = 0;
        bit          mpend = 0;
        logic [4:0]  pa = '0;
        logic [10:0] pd = '0;
        logic [3:0]  ma = '0;
        logic [3:0]  mb = '0;
        exp_t        e;
        @(negedge clk);
        start = 1'b1;
        while (cyc < 4000 && after != 0) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
            if (fpend) begin
                checks++;
                if (!fm_valid || fm_addr !== pa || fm_data !== pd) begin
                    errors++;
                    $display("FAIL fm_stable: valid=%0b addr=%0d data=%0d, required valid=1 addr=%0d data=%0d",
                             fm_valid, fm_addr, fm_data, pa, pd);
                end
            end
            if (mpend) begin
                checks++;
                if (!mul_req || mul_a !== ma || mul_b !== mb) begin
                    errors++;
                    $display("FAIL mul_stable: req=%0b a=%0d b=%0d, required req=1 a=%0d b=%0d",
                             mul_req, mul_a, mul_b, ma, mb);
                end
            end
            mpend = mul_req && !mul_ack;
            ma    = mul_a;
            mb    = mul_b;
            if (done) ndone++;
            if (fm_valid && first_valid < 0) first_valid = cyc;
            if (fm_valid && fm_addr == stall_addr && stall_left > 0) begin
                fm_ready = 1'b0;
                stall_left--;
            end else begin
                fm_ready = 1'b1;
            end
            fpend = fm_valid && !fm_ready;
            pa    = fm_addr;
            pd    = fm_data;
            if (fm_valid && fm_ready) begin
                npix++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got addr=%0d data=%0d, required no pixel", fm_addr, fm_data);
                end else begin
                    e = sb.pop_front();
                    if (fm_addr !== e.addr || fm_data !== e.data) begin
                        errors++;
                        $display("FAIL pixel: addr=%0d data=%0d, required addr=%0d data=%0d",
                                 fm_addr, fm_data, e.addr, e.data);
                    end
                end
            end
            if (after > 0) after--;
            else if (done && after < 0) after = 5;
        end
        fm_ready = 1'b0;
        start    = 1'b0;
        checks++;
        if (after != 0) begin
            errors++;
            $display("FAIL pass_timeout: ran %0d cycles, required done within 4000", cyc);
        end
        checks++;
        if (npix != 25) begin
            errors++;
            $display("FAIL pixel_count: got %0d, required 25", npix);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL done_cycles: got %0d, required 1", ndone);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_left: %0d pixels missing, required 0", sb.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after: got %0b, required 0", busy);
        end
        if (check_latency) begin
            checks++;
            if (first_valid < 36) begin
                errors++;
                $display("FAIL latency: first fm_valid at cycle %0d, required >= 36", first_valid);
            end
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mul_req !== 1'b0 || fm_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%0b done=%0b req=%0b valid=%0b, required all 0",
                     busy, done, mul_req, fm_valid);
        end
        checks++;
        if (img_addr !== 6'd0 || ker_addr !== 4'd0 || fm_addr !== 5'd0 || fm_data !== 11'd0 ||
            mul_a !== 4'd0 || mul_b !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: img=%0d ker=%0d fa=%0d fd=%0d a=%0d b=%0d, required all 0",
                     img_addr, ker_addr, fm_addr, fm_data, mul_a, mul_b);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_all_ones();
        load_roms(0);
        ack_delay = 0;
        push_expected();
        collect_pass(-1, -1, 1'b1);
    endtask

    task automatic test_identity_kernel();
        load_roms(1);
        ack_delay = 0;
        stray_ack = 1'b1;
        push_expected();
        collect_pass(-1, -1, 1'b1);
        stray_ack = 1'b0;
    endtask

    task automatic test_max_values();
        load_roms(2);
        ack_delay = 0;
        push_expected();
        checks++;
        if (sb[0].data !== 11'd2025) begin
            errors++;
            $display("FAIL max_model: got %0d, required 2025", sb[0].data);
        end
        collect_pass(-1, -1, 1'b1);
    endtask

    task automatic test_backpressure();
        load_roms(0);
        ack_delay = 3;
        push_expected();
        collect_pass(3, -1, 1'b0);
        ack_delay = 0;
    endtask

    task automatic test_random();
        load_roms(3);
        ack_delay = 1;
        push_expected();
        collect_pass(17, -1, 1'b0);
        ack_delay = 0;
    endtask

    task automatic test_reset_mid_pass();
        int cyc = 0;
        int bad = 0;
        load_roms(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 2000 && !(fm_valid && fm_addr == 5'd10)) begin
            fm_ready = 1'b1;
            @(negedge clk);
            cyc++;
        end
        fm_ready = 1'b0;
        checks++;
        if (!(fm_valid && fm_addr == 5'd10)) begin
            errors++;
            $display("FAIL reach_pix10: fm_valid=%0b fm_addr=%0d, required 1/10", fm_valid, fm_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || fm_valid !== 1'b0 || done !== 1'b0 || mul_req !== 1'b0 ||
            fm_addr !== 5'd0 || fm_data !== 11'd0 || img_addr !== 6'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%0b valid=%0b done=%0b req=%0b fa=%0d fd=%0d img=%0d, required all 0",
                     busy, fm_valid, done, mul_req, fm_addr, fm_data, img_addr);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fm_ready = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (fm_valid || done || busy) bad++;
        end
        fm_ready = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_quiet: %0d active cycles, required 0", bad);
        end
        push_expected();
        collect_pass(-1, -1, 1'b1);
    endtask

    task automatic test_back_to_back();
        load_roms(1);
        ack_delay = 0;
        push_expected();
        collect_pass(-1, 10, 1'b0);
        push_expected();
        collect_pass(-1, 150, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) img_rom[i] = '0;
        for (int i = 0; i < 16; i++) ker_rom[i] = '0;
        test_reset();
        test_all_ones();
        test_identity_kernel();
        test_max_values();
        test_backpressure();
        test_random();
        test_reset_mid_pass();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_scheduler.md
CONV_SCHEDULER -- requirements
Module: conv_scheduler

Interface
REQ-001 Parameters SHALL be: IMG_SIZE, default 7, image side in pixels; KERNEL_SIZE, default 3, kernel side; RES_SIZE, fixed at IMG_SIZE-KERNEL_SIZE+1, result side.
REQ-002 Ports SHALL be, in this order, one per line:
clk  in  1  single clock; all state changes on its rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a full convolution pass when idle
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last feature-map pixel is accepted
img_addr  out  6  image ROM read address, row-major
img_data  in  4  image ROM data, valid one cycle after img_addr
ker_addr  out  4  kernel ROM read address, row-major
ker_data  in  4  kernel ROM data, valid one cycle after ker_addr
mul_req  out  1  multiplier request; operands held stable while high
mul_a  out  4  image operand
mul_b  out  4  kernel operand
mul_ack  in  1  multiplier completion; mul_prod valid in the same cycle
mul_prod  in  8  unsigned product
fm_valid  out  1  feature-map pixel available
fm_ready  in  1  consumer accepts the pixel when fm_valid and fm_ready are both high
fm_addr  out  5  result index = RES_SIZE*row + col
fm_data  out  11  unsigned window sum

Function
REQ-003 The FSM SHALL have the states IDLE, FETCH, WAIT_ROM, MUL, ACC, EMIT and FIN.
REQ-004 IDLE: start=1 SHALL clear the window (wr, wc) and tap (kr, kc) counters and the accumulator, then move to FETCH; start=0 SHALL hold IDLE.
REQ-005 FETCH SHALL drive img_addr = IMG_SIZE*(wr+kr) + (wc+kc) and ker_addr = KERNEL_SIZE*kr + kc for one cycle, then move to WAIT_ROM.
REQ-006 WAIT_ROM SHALL register img_data into mul_a and ker_data into mul_b, then move to MUL.
REQ-007 MUL SHALL hold mul_req=1 with mul_a/mul_b stable until mul_ack=1, then move to ACC; mul_req SHALL be 0 in every other state.
REQ-008 ACC SHALL add the product, zero-extended to 11 bits, to the accumulator (max 9*225 = 2025, so no overflow). If the tap is not the last, it SHALL advance kc, wrapping to 0 and incrementing kr at KERNEL_SIZE, and return to FETCH. Otherwise it SHALL move to EMIT.
REQ-009 EMIT SHALL present fm_valid=1, with fm_addr and fm_data held stable until fm_ready=1.
REQ-010 On acceptance in EMIT, the block SHALL clear the accumulator and tap counters and advance wc, wrapping to 0 and incrementing wr at RES_SIZE. If the accepted pixel was index RES_SIZE*RES_SIZE-1 it SHALL move to FIN, otherwise to FETCH.
REQ-011 FIN SHALL assert done for exactly one cycle, then move to IDLE.
REQ-012 busy SHALL be 1 in every state except IDLE.
REQ-013 start while busy=1 SHALL be ignored.
REQ-014 A mul_ack outside MUL SHALL be ignored.
REQ-015 Per-tap minimum latency SHALL be 4 cycles (FETCH, WAIT_ROM, MUL with same-cycle ack, ACC). First fm_valid SHALL occur no earlier than 36 cycles after start with zero-wait ack.
REQ-016 Exactly RES_SIZE*RES_SIZE pixels SHALL be emitted per pass, in row-major order, with no skipped or duplicated index.

Reset
REQ-017 rst_n=0 SHALL immediately force IDLE and drive busy, done, mul_req and fm_valid to 0; all addresses, operands, fm_addr, fm_data, counters and the accumulator to 0.
REQ-018 Reset asserted mid-pass SHALL abort the pass with no further fm_valid or done. After release, the block SHALL wait for a new start.

Structure
REQ-019 The package conv_pkg SHALL hold IMG_SIZE, KERNEL_SIZE, RES_SIZE, the address widths and the state enumeration.
REQ-020 Address arithmetic SHALL live in one sub-module, conv_addr_gen: combinational mapping from (wr, wc, kr, kc) to img_addr and ker_addr.

Verification
REQ-021 All-ones image and kernel, zero-wait ack -> 25 pixels, each fm_data = 9, fm_addr 0..24 in order, then done pulses once.
REQ-022 Image[i] = i mod 16, kernel with centre = 1 and all other taps 0 -> fm_data at (r,c) = ((r+1)*7 + c+1) mod 16.
REQ-023 All image and kernel values 15 -> every fm_data = 2025.
REQ-024 fm_ready held low 5 cycles on pixel 3, and mul_ack delayed 3 cycles on every tap -> fm_addr/fm_data and mul_a/mul_b stay stable throughout, and results match REQ-021.
REQ-025 rst_n pulsed low during pixel 10 -> outputs zero at once and no done; a new start then produces the full 25-pixel pass.
REQ-026 start re-pulsed while busy -> ignored, and exactly 25 pixels and one done are observed.
